// File: rtl/vend_fsm_param.sv
// Parametrised coin-accumulating vending FSM.
// Dispenses one item per sale, then returns change as half-unit pulses.
module vend_fsm_param #(
    parameter int unsigned PRICE  = 5,
    parameter int unsigned CW     = 4,
    parameter int unsigned SOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pi_money_half,
    input  logic              pi_money_one,
    input  logic              pi_cancel,
    output logic              po_cola,
    output logic              po_back_half,
    output logic              po_reject,
    output logic              po_busy,
    output logic [CW-1:0]     po_credit,
    output logic [SOLD_W-1:0] po_sold_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        VEND,
        CHANGE
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [CW-1:0]     change_q, change_d;
    logic              reject_q, reject_d;
    logic [SOLD_W-1:0] sold_q, sold_d;

    logic [CW-1:0] coin_v;
    logic [CW-1:0] sum;
    logic          coin_any;

    assign coin_v   = CW'({pi_money_one, pi_money_half});
    assign sum      = credit_q + coin_v;
    assign coin_any = pi_money_half | pi_money_one;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            change_q <= '0;
            reject_q <= 1'b0;
            sold_q   <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            reject_q <= reject_d;
            sold_q   <= sold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        reject_d = 1'b0;
        sold_d   = sold_q;
        unique case (state_q)
            IDLE, COLLECT: begin
                // Cancel takes priority, even over a completing coin
                if (pi_cancel) begin
                    credit_d = '0;
                    change_d = sum;
                    state_d  = (sum != '0) ? CHANGE : IDLE;
                end else if (sum >= CW'(PRICE)) begin
                    credit_d = '0;
                    change_d = sum - CW'(PRICE);
                    state_d  = VEND;
                end else if (sum != '0) begin
                    credit_d = sum;
                    state_d  = COLLECT;
                end else begin
                    state_d  = IDLE;
                end
            end
            VEND: begin
                reject_d = coin_any;
                sold_d   = sold_q + SOLD_W'(1);
                state_d  = (change_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin_any;
                change_d = change_q - CW'(1);
                if (change_q == CW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign po_cola      = (state_q == VEND);
    assign po_back_half = (state_q == CHANGE);
    assign po_busy      = (state_q == VEND) || (state_q == CHANGE);
    assign po_reject    = reject_q;
    assign po_credit    = credit_q;
    assign po_sold_cnt  = sold_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: directed vector table, corner sequences,
// and randomized traffic against a credit/refund reference model.
module tb_vend_fsm_param;

    localparam int PRICE  = 5;
    localparam int CW     = 4;
    localparam int SOLD_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic in_h, in_o, in_c;
    logic cola, back, rej, busy;
    logic [CW-1:0] credit;
    logic [SOLD_W-1:0] sold;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_fsm_param #(.PRICE(PRICE), .CW(CW), .SOLD_W(SOLD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pi_money_half(in_h),
        .pi_money_one (in_o),
        .pi_cancel    (in_c),
        .po_cola      (cola),
        .po_back_half (back),
        .po_reject    (rej),
        .po_busy      (busy),
        .po_credit    (credit),
        .po_sold_cnt  (sold)
    );

    typedef struct {
        logic h, o, c;
        logic cola, back, busy, rej;
        int   credit;
        int   sold;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic h, logic o, logic c, logic ec,
                                logic eb, logic ebz, logic er,
                                int cr, int s);
        vec_t r;
        r.h = h; r.o = o; r.c = c;
        r.cola = ec; r.back = eb; r.busy = ebz; r.rej = er;
        r.credit = cr; r.sold = s;
        return r;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic chk_all(string tag, int ec, int eb, int ebz, int er,
                           int ecr, int es);
        chk({tag, ".cola"}, cola, ec);
        chk({tag, ".back"}, back, eb);
        chk({tag, ".busy"}, busy, ebz);
        chk({tag, ".reject"}, rej, er);
        chk({tag, ".credit"}, credit, ecr);
        chk({tag, ".sold"}, sold, es);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_h = 0; in_o = 0; in_c = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One input cycle, outputs settle #1 after the sampling edge
    task automatic drive(logic h, logic o, logic c);
        @(negedge clk);
        in_h = h; in_o = o; in_c = c;
        @(posedge clk);
        #1;
        in_h = 0; in_o = 0; in_c = 0;
    endtask

    task automatic sale();
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(0, 0, 0);
    endtask

    // Reference model: credit, one pending item, refund pulses owed
    int  m_credit, m_refund, m_sold;
    bit  m_vend, m_rej;

    task automatic m_reset();
        m_credit = 0; m_refund = 0; m_sold = 0;
        m_vend = 0; m_rej = 0;
    endtask

    task automatic m_step(bit h, bit o, bit c);
        int v, tot;
        v = int'(h) + 2 * int'(o);
        if (m_vend || m_refund > 0) begin
            m_rej = (v != 0);
            if (m_vend) begin
                m_vend = 0;
                m_sold = (m_sold + 1) % (1 << SOLD_W);
            end else begin
                m_refund--;
            end
        end else begin
            m_rej = 0;
            tot = m_credit + v;
            if (c) begin
                m_refund = tot;
                m_credit = 0;
            end else if (tot >= PRICE) begin
                m_vend   = 1;
                m_refund = tot - PRICE;
                m_credit = 0;
            end else begin
                m_credit = tot;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_h = 0; in_o = 0; in_c = 0;
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        do_reset();

        // h o c | cola back busy rej | credit sold
        vt.push_back(mk(1,0,0, 0,0,0,0, 1,0));
        vt.push_back(mk(0,0,0, 0,0,0,0, 1,0));
        vt.push_back(mk(1,0,0, 0,0,0,0, 2,0));
        vt.push_back(mk(0,0,0, 0,0,0,0, 2,0));
        vt.push_back(mk(1,0,0, 0,0,0,0, 3,0));
        vt.push_back(mk(0,0,0, 0,0,0,0, 3,0));
        vt.push_back(mk(1,0,0, 0,0,0,0, 4,0));
        vt.push_back(mk(0,0,0, 0,0,0,0, 4,0));
        vt.push_back(mk(1,0,0, 1,0,1,0, 0,0));
        vt.push_back(mk(0,0,0, 0,0,0,0, 0,1));
        vt.push_back(mk(0,1,0, 0,0,0,0, 2,1));
        vt.push_back(mk(0,1,0, 0,0,0,0, 4,1));
        vt.push_back(mk(0,1,0, 1,0,1,0, 0,1));
        vt.push_back(mk(0,0,0, 0,1,1,0, 0,2));
        vt.push_back(mk(0,0,0, 0,0,0,0, 0,2));
        vt.push_back(mk(0,1,0, 0,0,0,0, 2,2));
        vt.push_back(mk(0,1,0, 0,0,0,0, 4,2));
        vt.push_back(mk(1,1,0, 1,0,1,0, 0,2));
        vt.push_back(mk(1,0,0, 0,1,1,1, 0,3));
        vt.push_back(mk(0,1,0, 0,1,1,1, 0,3));
        vt.push_back(mk(0,0,0, 0,0,0,0, 0,3));
        vt.push_back(mk(0,1,0, 0,0,0,0, 2,3));
        vt.push_back(mk(1,0,0, 0,0,0,0, 3,3));
        vt.push_back(mk(0,0,1, 0,1,1,0, 0,3));
        vt.push_back(mk(0,0,0, 0,1,1,0, 0,3));
        vt.push_back(mk(0,0,0, 0,1,1,0, 0,3));
        vt.push_back(mk(0,0,0, 0,0,0,0, 0,3));
        vt.push_back(mk(0,0,1, 0,0,0,0, 0,3));
        vt.push_back(mk(0,1,1, 0,1,1,0, 0,3));
        vt.push_back(mk(0,0,0, 0,1,1,0, 0,3));
        vt.push_back(mk(0,0,0, 0,0,0,0, 0,3));
        vt.push_back(mk(0,1,0, 0,0,0,0, 2,3));
        vt.push_back(mk(1,1,1, 0,1,1,0, 0,3));

        foreach (vt[i]) begin
            in_h = vt[i].h; in_o = vt[i].o; in_c = vt[i].c;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].cola, vt[i].back,
                    vt[i].busy, vt[i].rej, vt[i].credit, vt[i].sold);
            @(negedge clk);
        end
        in_h = 0; in_o = 0; in_c = 0;
        repeat (6) @(posedge clk);

        // Async reset in the middle of a two-pulse refund
        do_reset();
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        chk("midchg.vend", cola, 1);
        drive(0, 0, 0);
        chk("midchg.back", back, 1);
        #2 rst = 1'b1;
        #1;
        chk_all("midchg.rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0);
            chk_all($sformatf("midchg.after%0d", k), 0, 0, 0, 0, 0, 0);
        end

        // Sales counter wrap and reset at full count
        do_reset();
        for (int k = 0; k < 255; k++) sale();
        chk("wrap.255", sold, 255);
        sale();
        chk("wrap.0", sold, 0);
        for (int k = 0; k < 255; k++) sale();
        chk("wrap.255b", sold, 255);
        #2 rst = 1'b1;
        #1;
        chk_all("wrap.rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0);
        chk_all("wrap.after", 0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional async resets
        do_reset();
        m_reset();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            in_h = ($urandom_range(99) < 30);
            in_o = ($urandom_range(99) < 30);
            in_c = ($urandom_range(99) < 8);
            rst  = ($urandom_range(999) < 5);
            @(posedge clk);
            if (rst) m_reset();
            else m_step(in_h, in_o, in_c);
            #1;
            chk_all("rand", int'(m_vend),
                    int'(!m_vend && m_refund > 0),
                    int'(m_vend || m_refund > 0), int'(m_rej),
                    m_credit, m_sold);
        end
        @(negedge clk);
        rst = 1'b0;
        in_h = 0; in_o = 0; in_c = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_fsm_param.md
# vend_fsm_param

Parametrised successor to the single-coin cola vending FSM. Accepts half-unit and one-unit coin pulses and accumulates credit against a configurable price. It dispenses one item, then returns change as a train of half-unit pulses; a cancel input refunds the collected credit. It also exports the live credit and a sales counter for the display/LED blocks that sit beside it on the board top level.

## Interface
Parameters:
- PRICE, 5, item price in half-units (5 = 2.5 units); legal range 1..2^CW-3
- CW, 4, credit/change counter width; must satisfy PRICE+2 <= 2^CW-1
- SOLD_W, 8, sales counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pi_money_half  in  1  one-cycle pulse: half-unit coin inserted (value 1)
- pi_money_one  in  1  one-cycle pulse: one-unit coin inserted (value 2)
- pi_cancel  in  1  one-cycle pulse: abort purchase, refund credit
- po_cola  out  1  item dispense pulse, exactly one cycle per sale
- po_back_half  out  1  change/refund pulse, one half-unit per high cycle
- po_reject  out  1  one-cycle pulse: coin arrived while busy and was not accepted
- po_busy  out  1  high in VEND and CHANGE states
- po_credit  out  CW  current accumulated credit, half-units
- po_sold_cnt  out  SOLD_W  completed sales, wraps modulo 2^SOLD_W

## Operation
- coin value per cycle: v = pi_money_half*1 + pi_money_one*2; both high in one cycle gives v = 3.
- States: IDLE (credit = 0), COLLECT (0 < credit < PRICE), VEND, CHANGE.
- IDLE/COLLECT, no cancel: sum = credit + v.
  - sum >= PRICE: go to VEND; change_cnt <= sum - PRICE; credit <= 0.
  - 0 < sum < PRICE: credit <= sum; state becomes COLLECT.
  - sum = 0: stay in IDLE.
- IDLE/COLLECT with pi_cancel: change_cnt <= credit + v and credit <= 0, even if sum >= PRICE (cancel wins; no item).
  - change_cnt > 0: go to CHANGE.
  - change_cnt = 0: stay in IDLE.
- VEND: lasts exactly one cycle; po_cola = 1; po_sold_cnt increments at the exit edge. Next state is CHANGE if change_cnt > 0, else IDLE.
- CHANGE: po_back_half = 1 every cycle; change_cnt decrements each edge. Exit to IDLE at the edge where change_cnt = 1.
- VEND/CHANGE: any coin pulse sets po_reject for the following cycle. Credit and change are unaffected. pi_cancel is ignored.
- All arithmetic is unsigned in CW bits. The parameter constraint guarantees no overflow, because the worst case sum is PRICE-1+3.

## Timing
- Reset: state IDLE, credit 0, change_cnt 0, po_cola 0, po_back_half 0, po_reject 0, po_busy 0, po_credit 0, po_sold_cnt 0. Applies immediately and asynchronously, including mid-VEND or mid-CHANGE. Any pending change is discarded.
- po_cola, po_back_half and po_busy are Moore outputs decoded from the registered state; po_reject is registered. All outputs are glitch-free relative to clk.
- Latency:
  - Coin sampled at edge N sets po_credit at edge N.
  - A completing coin at edge N makes po_cola high in cycle N..N+1.
  - The first po_back_half follows in cycle N+1..N+2.
  - Total pulses = change_cnt; there are no gaps between pulses.
- The minimum spacing between sales is 1 + change cycles. Coins are accepted again in the first cycle after the FSM is back in IDLE.
- A coin and pi_cancel in the same cycle: the coin is included in the refund.

## Test plan
- PRICE=5: five pi_money_half pulses spaced 2 cycles apart -> po_credit steps 1,2,3,4. One cycle after the 5th pulse, po_cola high for 1 cycle; no po_back_half; po_sold_cnt = 1.
- Three pi_money_one pulses -> credit 2,4, then sum 6. po_cola for 1 cycle, then exactly 1 po_back_half cycle, then IDLE.
- Credit 4, then pi_money_half and pi_money_one together (v=3, sum 7) -> po_cola, then 2 consecutive po_back_half cycles.
- Credit 3, then pi_cancel -> no po_cola; 3 po_back_half cycles; po_credit 0; po_sold_cnt unchanged. Cancel in IDLE with no coin -> no outputs.
- Coin pulse during VEND and during CHANGE -> po_reject high for 1 cycle after each. Change count is unchanged, and po_credit stays 0 after returning to IDLE.
- rst asserted mid-CHANGE with 2 pulses pending, and separately at sold count 255 with SOLD_W=8 -> after the reset, all outputs 0, IDLE, no further po_back_half. The wrap test sells once more and po_sold_cnt goes 255 -> 0.
